// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog reset generator.
// Holds the register offsets, the software reset key, the FSM state
// encoding and a small helper used to clamp the pulse length.
package wdt_pkg;

    // Register byte offsets
    localparam logic [7:0] ADDR_CTRL  = 8'h00;
    localparam logic [7:0] ADDR_STAT  = 8'h04;
    localparam logic [7:0] ADDR_SWRST = 8'h08;

    // Only this exact value written to SWRST requests a reset
    localparam logic [31:0] SWRST_KEY = 32'h5A5A_A5A5;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAssert  = 2'd1,
        StHoldoff = 2'd2
    } wdt_state_e;

    // A zero length still produces a one-cycle pulse
    function automatic logic [7:0] len_or_one(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

endpackage

// File: rtl/wdt_rst_sync.sv
// Synchronizer and falling-edge detector for the watchdog reset request.
// Ports:
//   clk      - destination clock
//   rst_b    - asynchronous active-low reset; all flops reset to 1
//   async_in - active-low request from another clock domain
//   fall     - one-cycle pulse when the synchronized request goes low
module wdt_rst_sync (
    input  logic clk,
    input  logic rst_b,
    input  logic async_in,
    output logic fall
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    // Reset to 1 so that releasing reset never looks like a falling edge
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign fall = !sync2_q && dly_q;

endmodule

// File: rtl/wdt_rst_gen.sv
// Watchdog / software reset stretcher with an APB register interface.
// A watchdog falling edge (when enabled) or a keyed software write starts a
// system reset pulse of max(LEN,1) cycles, followed by a lockout window.
// Ports:
//   pclk, prst_b        - clock and asynchronous active-low power-on reset
//   psel, penable,
//   pwrite, paddr,
//   pwdata, prdata      - APB slave, no wait states, combinational read data
//   wdt_sys_rst_b       - asynchronous active-low watchdog request
//   scan_mode           - DFT bypass: output follows prst_b
//   sys_rst_req_b       - stretched active-low system reset request
//   rst_busy            - high while a pulse or its lockout is in progress
module wdt_rst_gen
    import wdt_pkg::*;
#(
    parameter int unsigned HOLDOFF_CYC = 4,
    parameter int unsigned DEF_LEN     = 32
) (
    input  logic        pclk,
    input  logic        prst_b,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    input  logic        wdt_sys_rst_b,
    input  logic        scan_mode,
    output logic        sys_rst_req_b,
    output logic        rst_busy
);

    localparam logic [7:0] HoldLoad = 8'(HOLDOFF_CYC);
    localparam logic [7:0] LenReset = 8'(DEF_LEN);

    wdt_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       out_q;

    logic       en_q, en_d;
    logic [7:0] len_q, len_d;
    logic       wdt_seen_q, wdt_seen_d;
    logic       sw_seen_q, sw_seen_d;
    logic       lost_q, lost_d;
    logic [7:0] wdt_cnt_q, wdt_cnt_d;

    logic wdt_req;
    logic apb_wr;
    logic sw_req;
    logic busy;
    logic start;

    wdt_rst_sync u_sync (
        .clk      (pclk),
        .rst_b    (prst_b),
        .async_in (wdt_sys_rst_b),
        .fall     (wdt_req)
    );

    assign apb_wr = psel && penable && pwrite;
    assign sw_req = apb_wr && (paddr == ADDR_SWRST) && (pwdata == SWRST_KEY);
    assign busy   = (state_q != StIdle);
    assign start  = (state_q == StIdle) && ((wdt_req && en_q) || sw_req);

    // FSM next state and pulse/lockout counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAssert;
                    cnt_d   = len_or_one(len_q);
                end
            end
            StAssert: begin
                if (cnt_q <= 8'd1) begin
                    state_d = StHoldoff;
                    cnt_d   = HoldLoad;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StHoldoff: begin
                if (cnt_q <= 8'd1) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Register file next state; hardware sets are applied after W1C so set wins
    always_comb begin
        en_d       = en_q;
        len_d      = len_q;
        wdt_seen_d = wdt_seen_q;
        sw_seen_d  = sw_seen_q;
        lost_d     = lost_q;
        wdt_cnt_d  = wdt_cnt_q;

        if (apb_wr && (paddr == ADDR_CTRL)) begin
            en_d  = pwdata[0];
            len_d = pwdata[15:8];
        end

        if (apb_wr && (paddr == ADDR_STAT)) begin
            if (pwdata[0])  wdt_seen_d = 1'b0;
            if (pwdata[1])  sw_seen_d  = 1'b0;
            if (pwdata[2])  lost_d     = 1'b0;
            if (pwdata[31]) wdt_cnt_d  = 8'd0;
        end

        // Watchdog events are logged even when EN is clear
        if (wdt_req) begin
            wdt_seen_d = 1'b1;
            if (wdt_cnt_d != 8'hFF) begin
                wdt_cnt_d = wdt_cnt_d + 8'd1;
            end
        end
        if (sw_req) begin
            sw_seen_d = 1'b1;
        end
        if (busy && (wdt_req || sw_req)) begin
            lost_d = 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge prst_b) begin
        if (!prst_b) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            out_q      <= 1'b1;
            en_q       <= 1'b1;
            len_q      <= LenReset;
            wdt_seen_q <= 1'b0;
            sw_seen_q  <= 1'b0;
            lost_q     <= 1'b0;
            wdt_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            // Registered from the current state: output lags state by one cycle
            out_q      <= (state_q != StAssert);
            en_q       <= en_d;
            len_q      <= len_d;
            wdt_seen_q <= wdt_seen_d;
            sw_seen_q  <= sw_seen_d;
            lost_q     <= lost_d;
            wdt_cnt_q  <= wdt_cnt_d;
        end
    end

    always_comb begin
        prdata = 32'd0;
        if (psel && !pwrite) begin
            case (paddr)
                ADDR_CTRL: prdata = {16'd0, len_q, 7'd0, en_q};
                ADDR_STAT: prdata = {16'd0, wdt_cnt_q, 5'd0, lost_q, sw_seen_q, wdt_seen_q};
                default:   prdata = 32'd0;
            endcase
        end
    end

    assign sys_rst_req_b = scan_mode ? prst_b : out_q;
    assign rst_busy      = busy;

endmodule

// File: tb/tb_wdt_rst_gen.sv
module tb_wdt_rst_gen;
    import wdt_pkg::*;

    logic        pclk = 1'b0;
    logic        prst_b;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        wdt_sys_rst_b;
    logic        scan_mode;
    logic        sys_rst_req_b;
    logic        rst_busy;

    int total = 0;
    int bad   = 0;

    int   low_total  = 0;
    int   fall_total = 0;
    logic prev_out   = 1'b1;

    wdt_rst_gen #(
        .HOLDOFF_CYC (4),
        .DEF_LEN     (32)
    ) dut (
        .pclk          (pclk),
        .prst_b        (prst_b),
        .psel          (psel),
        .penable       (penable),
        .pwrite        (pwrite),
        .paddr         (paddr),
        .pwdata        (pwdata),
        .prdata        (prdata),
        .wdt_sys_rst_b (wdt_sys_rst_b),
        .scan_mode     (scan_mode),
        .sys_rst_req_b (sys_rst_req_b),
        .rst_busy      (rst_busy)
    );

    always #5 pclk = ~pclk;

    // Running tallies of low cycles and falling edges of the reset output
    always @(negedge pclk) begin
        if (!sys_rst_req_b) low_total++;
        if (prev_out && !sys_rst_req_b) fall_total++;
        prev_out = sys_rst_req_b;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = 32'd0;
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        #1;
        check(name, prdata, exp);
        @(negedge pclk);
        psel = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (4) @(negedge pclk);
        while (rst_busy && n < 400) begin
            @(negedge pclk);
            n++;
        end
        check("idle_reached", {31'd0, rst_busy}, 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];
    int   l0;
    int   f0;

    initial begin
        vecs[0]  = '{1'b0, ADDR_CTRL,  32'h0,         32'h0000_2001};
        vecs[1]  = '{1'b0, ADDR_STAT,  32'h0,         32'h0};
        vecs[2]  = '{1'b0, ADDR_SWRST, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 8'h0C,      32'h0,         32'h0};
        vecs[4]  = '{1'b1, ADDR_CTRL,  32'hFFFF_FFFF, 32'h0};
        vecs[5]  = '{1'b0, ADDR_CTRL,  32'h0,         32'h0000_FF01};
        vecs[6]  = '{1'b1, 8'h0C,      32'h0,         32'h0};
        vecs[7]  = '{1'b0, ADDR_CTRL,  32'h0,         32'h0000_FF01};
        vecs[8]  = '{1'b1, ADDR_CTRL,  32'h0000_0A01, 32'h0};
        vecs[9]  = '{1'b0, ADDR_CTRL,  32'h0,         32'h0000_0A01};
        vecs[10] = '{1'b1, ADDR_SWRST, 32'h1234_5678, 32'h0};
        vecs[11] = '{1'b0, ADDR_STAT,  32'h0,         32'h0};
        vecs[12] = '{1'b1, ADDR_STAT,  32'hFFFF_FFFF, 32'h0};
        vecs[13] = '{1'b0, ADDR_STAT,  32'h0,         32'h0};
        vecs[14] = '{1'b0, 8'h05,      32'h0,         32'h0};

        prst_b = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'd0; pwdata = 32'd0; wdt_sys_rst_b = 1'b1; scan_mode = 1'b0;

        #12;
        check("reset_out_high", {31'd0, sys_rst_req_b}, 32'd1);
        check("reset_busy_low", {31'd0, rst_busy}, 32'd0);
        @(negedge pclk);
        prst_b = 1'b1;
        repeat (2) @(negedge pclk);

        // Register access table
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
            else read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end
        check("no_pulse_during_table", low_total, 0);

        // Write phase reads zero
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = ADDR_CTRL;
        #1;
        check("read_while_write_zero", prdata, 32'd0);
        @(negedge pclk);
        psel = 1'b0; pwrite = 1'b0;

        // WDT pulse, LEN=10, latency to edge k+3
        l0 = low_total; f0 = fall_total;
        wdt_sys_rst_b = 1'b0;
        @(negedge pclk); check("lat_k",  {31'd0, sys_rst_req_b}, 32'd1);
        @(negedge pclk); check("lat_k1", {31'd0, sys_rst_req_b}, 32'd1);
        @(negedge pclk); check("lat_k2", {31'd0, sys_rst_req_b}, 32'd1);
        @(negedge pclk); check("lat_k3", {31'd0, sys_rst_req_b}, 32'd0);
        wdt_sys_rst_b = 1'b1;
        wait_idle();
        check("wdt_width", low_total - l0, 10);
        check("wdt_falls", fall_total - f0, 1);
        read_check("wdt_stat", ADDR_STAT, 32'h0000_0101);

        // Software key and wrong key
        l0 = low_total;
        apb_write(ADDR_SWRST, SWRST_KEY);
        wait_idle();
        check("sw_width", low_total - l0, 10);
        read_check("sw_stat", ADDR_STAT, 32'h0000_0103);
        l0 = low_total;
        apb_write(ADDR_SWRST, 32'h1234_5678);
        repeat (20) @(negedge pclk);
        check("badkey_width", low_total - l0, 0);
        read_check("badkey_stat", ADDR_STAT, 32'h0000_0103);

        // Retrigger during ASSERT, LEN rewrite mid-pulse
        apb_write(ADDR_STAT, 32'h8000_0007);
        read_check("stat_cleared", ADDR_STAT, 32'h0);
        l0 = low_total; f0 = fall_total;
        wdt_sys_rst_b = 1'b0;
        repeat (3) @(negedge pclk);
        apb_write(ADDR_CTRL, 32'h0000_0301);
        wdt_sys_rst_b = 1'b1;
        repeat (3) @(negedge pclk);
        wdt_sys_rst_b = 1'b0;
        repeat (3) @(negedge pclk);
        wdt_sys_rst_b = 1'b1;
        wait_idle();
        check("retrig_width", low_total - l0, 10);
        check("retrig_falls", fall_total - f0, 1);
        read_check("retrig_stat", ADDR_STAT, 32'h0000_0205);
        apb_write(ADDR_STAT, 32'h0000_0007);
        read_check("w1c_keeps_cnt", ADDR_STAT, 32'h0000_0200);
        l0 = low_total;
        apb_write(ADDR_SWRST, SWRST_KEY);
        wait_idle();
        check("newlen_width", low_total - l0, 3);

        // Simultaneous wdt and software request
        apb_write(ADDR_STAT, 32'h8000_0007);
        apb_write(ADDR_CTRL, 32'h0000_0501);
        l0 = low_total; f0 = fall_total;
        wdt_sys_rst_b = 1'b0;
        @(negedge pclk);
        apb_write(ADDR_SWRST, SWRST_KEY);
        wdt_sys_rst_b = 1'b1;
        wait_idle();
        check("both_width", low_total - l0, 5);
        check("both_falls", fall_total - f0, 1);
        read_check("both_stat", ADDR_STAT, 32'h0000_0103);

        // EN=0, LEN=0
        apb_write(ADDR_STAT, 32'h8000_0007);
        apb_write(ADDR_CTRL, 32'h0000_0000);
        l0 = low_total;
        wdt_sys_rst_b = 1'b0;
        repeat (4) @(negedge pclk);
        wdt_sys_rst_b = 1'b1;
        repeat (20) @(negedge pclk);
        check("en0_width", low_total - l0, 0);
        read_check("en0_stat", ADDR_STAT, 32'h0000_0101);
        apb_write(ADDR_CTRL, 32'h0000_0001);
        l0 = low_total; f0 = fall_total;
        apb_write(ADDR_SWRST, SWRST_KEY);
        wait_idle();
        check("len0_width", low_total - l0, 1);
        check("len0_falls", fall_total - f0, 1);

        // Scan mode bypass
        scan_mode = 1'b1;
        l0 = low_total;
        wdt_sys_rst_b = 1'b0;
        repeat (5) @(negedge pclk);
        check("scan_out_high", {31'd0, sys_rst_req_b}, 32'd1);
        wdt_sys_rst_b = 1'b1;
        wait_idle();
        check("scan_width", low_total - l0, 0);
        #2 prst_b = 1'b0;
        #1 check("scan_tracks_low", {31'd0, sys_rst_req_b}, 32'd0);
        @(negedge pclk);
        prst_b = 1'b1;
        #1 check("scan_tracks_high", {31'd0, sys_rst_req_b}, 32'd1);
        scan_mode = 1'b0;
        repeat (3) @(negedge pclk);

        // Reset asserted mid-pulse
        apb_write(ADDR_SWRST, SWRST_KEY);
        repeat (6) @(negedge pclk);
        check("mid_pulse_low", {31'd0, sys_rst_req_b}, 32'd0);
        #2 prst_b = 1'b0;
        #1 check("abort_out_high", {31'd0, sys_rst_req_b}, 32'd1);
        check("abort_idle", {31'd0, rst_busy}, 32'd0);
        @(negedge pclk);
        prst_b = 1'b1;
        l0 = low_total;
        repeat (40) @(negedge pclk);
        check("abort_no_more", low_total - l0, 0);
        read_check("abort_ctrl", ADDR_CTRL, 32'h0000_2001);
        read_check("abort_stat", ADDR_STAT, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
